// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: constants and width helpers shared by the RX sampler and the RX control FSM.
package uart_rx_pkg;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   FRAME_BITS = 11;
    localparam int   MID_EDGE   = 4;

    function automatic int frame_bits(input int byte_width);
        return byte_width + 3;
    endfunction

    function automatic int mid_edge(input int prescale);
        return prescale / 2;
    endfunction

    function automatic int edge_width(input int prescale);
        return $clog2(prescale);
    endfunction

    function automatic int bit_width(input int byte_width);
        return $clog2(byte_width + 3);
    endfunction

    function automatic logic majority3(input logic [2:0] t);
        return (t[0] & t[1]) | (t[0] & t[2]) | (t[1] & t[2]);
    endfunction

endpackage

// File: rtl/uart_rx_majority_sampler.sv
// uart_rx_majority_sampler: captures the line at MID-1, MID, MID+1 and registers the
// majority vote with a one-cycle valid pulse at MID+2.
module uart_rx_majority_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_line,
    input  logic                            i_enable,
    input  logic [edge_width(PRESCALE)-1:0] i_edge_count,
    output logic                            o_sampled_bit,
    output logic                            o_sample_valid
);

    localparam int EW  = edge_width(PRESCALE);
    localparam int MID = mid_edge(PRESCALE);

    localparam logic [EW-1:0] TAP0_EDGE = EW'(MID - 1);
    localparam logic [EW-1:0] TAP1_EDGE = EW'(MID);
    localparam logic [EW-1:0] TAP2_EDGE = EW'(MID + 1);
    localparam logic [EW-1:0] VOTE_EDGE = EW'(MID + 2);

    logic [2:0] taps;

    // A capture skipped by a low enable leaves the stale tap in the vote.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            taps <= {3{IDLE_LEVEL}};
        end else if (i_enable) begin
            if (i_edge_count == TAP0_EDGE) taps[0] <= i_line;
            if (i_edge_count == TAP1_EDGE) taps[1] <= i_line;
            if (i_edge_count == TAP2_EDGE) taps[2] <= i_line;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sampled_bit  <= IDLE_LEVEL;
            o_sample_valid <= 1'b0;
        end else begin
            o_sample_valid <= i_enable && (i_edge_count == VOTE_EDGE);
            if (i_enable && (i_edge_count == VOTE_EDGE)) o_sampled_bit <= majority3(taps);
        end
    end

endmodule

// File: rtl/uart_rx_edge_bit_sampler.sv
// uart_rx_edge_bit_sampler: edge/bit counters and majority-vote sampler for the UART RX path.
// Define UART_RX_SYNC_EN to pass i_rx through an internal 2-flop synchronizer.
module uart_rx_edge_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE   = 8,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_rx,
    input  logic                             i_count_enable,
    input  logic                             i_sampling_enable,
    output logic                             o_rx_line,
    output logic [edge_width(PRESCALE)-1:0]  o_edge_count,
    output logic [bit_width(BYTE_WIDTH)-1:0] o_bit_count,
    output logic                             o_sampled_bit,
    output logic                             o_sample_valid
);

    localparam int EW = edge_width(PRESCALE);
    localparam int BW = bit_width(BYTE_WIDTH);

    localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(frame_bits(BYTE_WIDTH) - 1);

    logic line;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= {2{IDLE_LEVEL}};
        else          sync_q <= {sync_q[0], i_rx};
    end

    assign line = sync_q[1];
`else
    assign line = i_rx;
`endif

    assign o_rx_line = line;

    // A low enable clears both counters, including a mid-frame abort from the FSM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_edge_count <= '0;
            o_bit_count  <= '0;
        end else if (!i_count_enable) begin
            o_edge_count <= '0;
            o_bit_count  <= '0;
        end else if (o_edge_count == EDGE_LAST) begin
            o_edge_count <= '0;
            o_bit_count  <= (o_bit_count == BIT_LAST) ? '0 : o_bit_count + BW'(1);
        end else begin
            o_edge_count <= o_edge_count + EW'(1);
        end
    end

    uart_rx_majority_sampler #(
        .PRESCALE(PRESCALE)
    ) u_sampler (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_line        (line),
        .i_enable      (i_sampling_enable),
        .i_edge_count  (o_edge_count),
        .o_sampled_bit (o_sampled_bit),
        .o_sample_valid(o_sample_valid)
    );

endmodule
